// File: rtl/decode_stage_param.sv
// rtl/decode_stage_param.sv - parametrised decode stage: register file, forwarding, load-use stall, valid/ready output
// NREGS=16 selects RV32E behaviour: indices with bit 4 set are illegal and never written.
module decode_stage_param #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NFWD  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instr_in,
  input  logic [XLEN-1:0]      pc_in,
  input  logic                 valid_in,
  output logic                 ready_out,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [NFWD*5-1:0]    fwd_rd,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  input  logic [NFWD-1:0]      fwd_data_ready,
  input  logic                 wb_en,
  input  logic [4:0]           wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 flush_in,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic [31:0]          instr_out,
  output logic [XLEN-1:0]      pc_out,
  output logic [XLEN-1:0]      rs1_data_out,
  output logic [XLEN-1:0]      rs2_data_out,
  output logic                 illegal_reg_out
);

  localparam int AW = $clog2(NREGS);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Only 32 and 16 entries are supported, so bit 4 alone decides range.
  function automatic logic idx_ok(input logic [4:0] idx);
    return (NREGS == 32) || (idx[4] == 1'b0);
  endfunction

  logic [XLEN-1:0] rf_q [NREGS];

  logic [6:0]      opcode;
  logic [4:0]      rs1_idx, rs2_idx, rd_idx;
  logic            rs1_used, rs2_used;
  logic            wb_we;
  logic [XLEN-1:0] rf_rs1, rf_rs2;

  logic            f1_hit, f1_rdy, f2_hit, f2_rdy;
  logic [XLEN-1:0] f1_data, f2_data;
  logic            rs1_fwd, rs2_fwd, rs1_haz, rs2_haz;
  logic            hazard, accept;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            illegal;

  logic            valid_q, valid_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic            illegal_q, illegal_d;

  assign opcode  = instr_in[6:0];
  assign rd_idx  = instr_in[11:7];
  assign rs1_idx = instr_in[19:15];
  assign rs2_idx = instr_in[24:20];

  assign rs1_used = !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
  assign rs2_used = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);

  assign wb_we = wb_en && (wb_rd != 5'd0) && idx_ok(wb_rd);

  // Register-file read with write-through from the same-cycle writeback.
  always_comb begin
    rf_rs1 = '0;
    rf_rs2 = '0;
    if (rs1_idx != 5'd0 && idx_ok(rs1_idx)) begin
      if (wb_we && wb_rd == rs1_idx) rf_rs1 = wb_data;
      else                           rf_rs1 = rf_q[rs1_idx[AW-1:0]];
    end
    if (rs2_idx != 5'd0 && idx_ok(rs2_idx)) begin
      if (wb_we && wb_rd == rs2_idx) rf_rs2 = wb_data;
      else                           rf_rs2 = rf_q[rs2_idx[AW-1:0]];
    end
  end

  // Walk from oldest to youngest so the lowest matching channel wins.
  always_comb begin
    f1_hit  = 1'b0;
    f1_rdy  = 1'b0;
    f1_data = '0;
    f2_hit  = 1'b0;
    f2_rdy  = 1'b0;
    f2_data = '0;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && fwd_rd[i*5 +: 5] == rs1_idx) begin
        f1_hit  = 1'b1;
        f1_rdy  = fwd_data_ready[i];
        f1_data = fwd_data[i*XLEN +: XLEN];
      end
      if (fwd_valid[i] && fwd_rd[i*5 +: 5] == rs2_idx) begin
        f2_hit  = 1'b1;
        f2_rdy  = fwd_data_ready[i];
        f2_data = fwd_data[i*XLEN +: XLEN];
      end
    end
  end

  assign rs1_fwd = rs1_used && (rs1_idx != 5'd0) && f1_hit;
  assign rs2_fwd = rs2_used && (rs2_idx != 5'd0) && f2_hit;
  assign rs1_haz = rs1_fwd && !f1_rdy;
  assign rs2_haz = rs2_fwd && !f2_rdy;

  assign rs1_val = rs1_fwd ? f1_data : rf_rs1;
  assign rs2_val = rs2_fwd ? f2_data : rf_rs2;

  assign hazard    = valid_in && (rs1_haz || rs2_haz);
  assign ready_out = !hazard && (!valid_q || ready_in);
  assign accept    = valid_in && !hazard && (!valid_q || ready_in) && !flush_in;

  assign illegal = (NREGS == 16) && (rs1_idx[4] || rs2_idx[4] || rd_idx[4]);

  always_comb begin
    valid_d   = valid_q;
    instr_d   = instr_q;
    pc_d      = pc_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    illegal_d = illegal_q;
    if (flush_in) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d   = 1'b1;
      instr_d   = instr_in;
      pc_d      = pc_in;
      rs1_d     = rs1_val;
      rs2_d     = rs2_val;
      illegal_d = illegal;
    end else if (ready_in) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      instr_q   <= '0;
      pc_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      illegal_q <= illegal_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (wb_we) begin
      rf_q[wb_rd[AW-1:0]] <= wb_data;
    end
  end

  assign valid_out       = valid_q;
  assign instr_out       = instr_q;
  assign pc_out          = pc_q;
  assign rs1_data_out    = rs1_q;
  assign rs2_data_out    = rs2_q;
  assign illegal_reg_out = illegal_q;

endmodule

// File: tb/tb_decode_stage_param.sv
// tb/tb_decode_stage_param.sv - directed bench for decode_stage_param (NREGS=32 and NREGS=16 instances)
module tb_decode_stage_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_in, pc_in;
  logic        valid_in, flush_in, ready_in;
  logic [2:0]  fwd_valid, fwd_data_ready;
  logic [14:0] fwd_rd;
  logic [95:0] fwd_data;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  logic        ready_a, valid_a, ill_a;
  logic [31:0] instr_a, pc_a, rs1_a, rs2_a;
  logic        ready_b, valid_b, ill_b;
  logic [31:0] instr_b, pc_b, rs1_b, rs2_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_stage_param #(.XLEN(32), .NREGS(32), .NFWD(3)) u_dut (
    .clk(clk), .rst(rst), .instr_in(instr_in), .pc_in(pc_in), .valid_in(valid_in),
    .ready_out(ready_a), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .fwd_data_ready(fwd_data_ready), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush_in(flush_in), .valid_out(valid_a), .ready_in(ready_in), .instr_out(instr_a),
    .pc_out(pc_a), .rs1_data_out(rs1_a), .rs2_data_out(rs2_a), .illegal_reg_out(ill_a)
  );

  decode_stage_param #(.XLEN(32), .NREGS(16), .NFWD(3)) u_dut16 (
    .clk(clk), .rst(rst), .instr_in(instr_in), .pc_in(pc_in), .valid_in(valid_in),
    .ready_out(ready_b), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .fwd_data_ready(fwd_data_ready), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush_in(flush_in), .valid_out(valid_b), .ready_in(ready_in), .instr_out(instr_b),
    .pc_out(pc_b), .rs1_data_out(rs1_b), .rs2_data_out(rs2_b), .illegal_reg_out(ill_b)
  );

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {f7, rs2, rs1, 3'b000, rd, op};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  localparam logic [6:0] OP  = 7'b0110011;
  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] LUI = 7'b0110111;

  logic [31:0] lui_i;

  initial begin
    rst = 1'b0; instr_in = '0; pc_in = '0; valid_in = 1'b0; flush_in = 1'b0; ready_in = 1'b1;
    fwd_valid = '0; fwd_data_ready = '1; fwd_rd = '0; fwd_data = '0;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0;
    cyc(); cyc();
    chk("reset_valid", {31'b0, valid_a}, 32'd0);
    chk("reset_instr", instr_a, 32'd0);
    chk("reset_pc", pc_a, 32'd0);
    chk("reset_rs1", rs1_a, 32'd0);
    chk("reset_rs2", rs2_a, 32'd0);
    chk("reset_illegal", {31'b0, ill_a}, 32'd0);
    chk("reset_ready", {31'b0, ready_a}, 32'd1);

    // Basic register-file write then read
    rst = 1'b1;
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
    cyc();
    wb_en = 1'b0;
    instr_in = rtype(7'd0, 5'd0, 5'd5, 5'd1, OP); pc_in = 32'h100; valid_in = 1'b1;
    cyc();
    valid_in = 1'b0;
    chk("rf_valid", {31'b0, valid_a}, 32'd1);
    chk("rf_rs1", rs1_a, 32'hDEADBEEF);
    chk("rf_rs2", rs2_a, 32'd0);
    chk("rf_pc", pc_a, 32'h100);
    chk("rf_instr", instr_a, 32'h000280B3);

    // Write-through
    instr_in = rtype(7'd0, 5'd7, 5'd7, 5'd2, OP); valid_in = 1'b1;
    wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'h1234;
    cyc();
    chk("wt_rs1", rs1_a, 32'h1234);
    chk("wt_rs2", rs2_a, 32'h1234);
    instr_in = rtype(7'd0, 5'd0, 5'd0, 5'd3, OP);
    wb_rd = 5'd0; wb_data = 32'hFF;
    cyc();
    wb_en = 1'b0;
    chk("x0_rs1", rs1_a, 32'd0);
    instr_in = rtype(7'd0, 5'd5, 5'd7, 5'd2, OP);
    cyc();
    chk("rf_x7", rs1_a, 32'h1234);
    chk("rf_x5", rs2_a, 32'hDEADBEEF);

    // Forwarding priority
    fwd_valid = 3'b110; fwd_rd = {5'd3, 5'd3, 5'd0};
    fwd_data = {32'hB, 32'hA, 32'hC}; fwd_data_ready = 3'b111;
    instr_in = rtype(7'd0, 5'd0, 5'd3, 5'd1, OP);
    cyc();
    chk("fwd_ch1", rs1_a, 32'hA);
    fwd_valid = 3'b111; fwd_rd = {5'd3, 5'd3, 5'd3};
    cyc();
    chk("fwd_ch0", rs1_a, 32'hC);
    instr_in = rtype(7'd0, 5'd3, 5'd0, 5'd1, OP);
    cyc();
    chk("fwd_rs2", rs2_a, 32'hC);
    instr_in = rtype(7'd0, 5'd3, 5'd0, 5'd1, OPI);
    cyc();
    chk("unused_rs2_nofwd", rs2_a, 32'd0);
    fwd_data_ready = 3'b110;
    instr_in = rtype(7'd0, 5'd0, 5'd3, 5'd1, OP);
    #1;
    chk("lowprio_ignored_ready", {31'b0, ready_a}, 32'd0);

    // Load-use stall
    fwd_valid = 3'b001; fwd_rd = {5'd0, 5'd0, 5'd4}; fwd_data_ready = 3'b000;
    fwd_data = {32'h0, 32'h0, 32'h55};
    instr_in = rtype(7'b0100000, 5'd2, 5'd4, 5'd1, OP);
    #1;
    chk("lu_ready", {31'b0, ready_a}, 32'd0);
    cyc();
    chk("lu_bubble", {31'b0, valid_a}, 32'd0);
    fwd_data_ready = 3'b001;
    #1;
    chk("lu_ready_again", {31'b0, ready_a}, 32'd1);
    cyc();
    chk("lu_valid", {31'b0, valid_a}, 32'd1);
    chk("lu_rs1", rs1_a, 32'h55);
    fwd_data_ready = 3'b000;
    lui_i = rtype(7'd0, 5'd0, 5'd4, 5'd4, LUI);
    instr_in = lui_i;
    #1;
    chk("lui_ready", {31'b0, ready_a}, 32'd1);
    cyc();
    chk("lui_instr", instr_a, lui_i);

    // Backpressure, flush, mid-operation reset
    fwd_valid = 3'b000;
    ready_in = 1'b0;
    instr_in = rtype(7'd0, 5'd1, 5'd1, 5'd9, OP); pc_in = 32'h200;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", {31'b0, ready_a}, 32'd0);
      cyc();
      chk("bp_valid", {31'b0, valid_a}, 32'd1);
      chk("bp_instr", instr_a, lui_i);
    end
    flush_in = 1'b1;
    cyc();
    flush_in = 1'b0; valid_in = 1'b0;
    chk("flush_valid", {31'b0, valid_a}, 32'd0);
    cyc();
    chk("flush_dropped", {31'b0, valid_a}, 32'd0);
    valid_in = 1'b1;
    cyc();
    valid_in = 1'b0;
    chk("hold_valid", {31'b0, valid_a}, 32'd1);
    rst = 1'b0;
    cyc();
    rst = 1'b1; ready_in = 1'b1;
    chk("mrst_valid", {31'b0, valid_a}, 32'd0);
    chk("mrst_instr", instr_a, 32'd0);
    chk("mrst_pc", pc_a, 32'd0);
    chk("mrst_rs1", rs1_a, 32'd0);

    // RV32E mode
    instr_in = rtype(7'd0, 5'd2, 5'd1, 5'd17, OP); valid_in = 1'b1;
    cyc();
    valid_in = 1'b0;
    chk("e_illegal16", {31'b0, ill_b}, 32'd1);
    chk("e_illegal32", {31'b0, ill_a}, 32'd0);
    wb_en = 1'b1; wb_rd = 5'd20; wb_data = 32'h77;
    cyc();
    wb_en = 1'b0;
    instr_in = rtype(7'd0, 5'd0, 5'd4, 5'd1, OP); valid_in = 1'b1;
    cyc();
    chk("e_nowrite_alias", rs1_b, 32'd0);
    chk("e_legal16", {31'b0, ill_b}, 32'd0);
    instr_in = rtype(7'd0, 5'd0, 5'd20, 5'd1, OP);
    cyc();
    valid_in = 1'b0;
    chk("x20_written32", rs1_a, 32'h77);
    chk("x20_read16", rs1_b, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
